// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: control bundle layout, ALUOp encodings,
// and the hard-wired zero register index.
package mips_pkg;

  // Control bundle: {RegWrite,MemRead,MemWrite,MemToReg,ALUSrc,Branch,ALUOp[2:0]}
  localparam int CTRL_W        = 9;
  localparam int CTRL_REGWRITE = 8;
  localparam int CTRL_MEMREAD  = 7;
  localparam int CTRL_MEMWRITE = 6;
  localparam int CTRL_MEMTOREG = 5;
  localparam int CTRL_ALUSRC   = 4;
  localparam int CTRL_BRANCH   = 3;
  localparam int CTRL_ALUOP_LO = 0;
  localparam int ALUOP_W       = 3;

  typedef enum logic [ALUOP_W-1:0] {
    ALUOP_ADD   = 3'b000,
    ALUOP_SUB   = 3'b001,
    ALUOP_RTYPE = 3'b010,
    ALUOP_AND   = 3'b011,
    ALUOP_OR    = 3'b100,
    ALUOP_SLT   = 3'b101
  } aluop_e;

  // Register $0 reads as zero and is never a real producer.
  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/id_ex_stage_if.sv
// ID->EX stage bundle: decoded ID fields and forwarding sources in,
// registered EX fields, forwarded operands and stall out.
//
// Handshake: id_valid marks a real instruction in ID. While stall is high the
// ID side must hold every id_* field unchanged for the next cycle; the stage
// has already loaded a bubble and will take the same instruction once stall
// drops. flush overrides stall: the ID instruction is discarded, not held.
interface id_ex_stage_if import mips_pkg::*; #(
  parameter int DW     = 32,
  parameter int RW     = 5,
  parameter int CTRL_W = mips_pkg::CTRL_W,
  parameter int CNT_W  = 16
);
  logic              id_valid;
  logic [RW-1:0]     id_rs;
  logic [RW-1:0]     id_rt;
  logic [RW-1:0]     id_rd;
  logic              id_uses_rt;
  logic [CTRL_W-1:0] id_ctrl;
  logic [DW-1:0]     id_imm;
  logic [DW-1:0]     id_regA;
  logic [DW-1:0]     id_regB;
  logic              flush;
  logic              exmem_regwrite;
  logic [RW-1:0]     exmem_rd;
  logic [DW-1:0]     exmem_data;
  logic              memwb_regwrite;
  logic [RW-1:0]     memwb_rd;
  logic [DW-1:0]     memwb_data;
  logic              stall;
  logic              ex_valid;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [RW-1:0]     ex_rs;
  logic [RW-1:0]     ex_rt;
  logic [RW-1:0]     ex_rd;
  logic [DW-1:0]     ex_imm;
  logic [DW-1:0]     ex_opA;
  logic [DW-1:0]     ex_opB;
  logic [DW-1:0]     ex_store_data;
  logic [CNT_W-1:0]  bubble_cnt;

  modport master (
    output id_valid, id_rs, id_rt, id_rd, id_uses_rt, id_ctrl, id_imm, id_regA, id_regB,
           flush, exmem_regwrite, exmem_rd, exmem_data, memwb_regwrite, memwb_rd, memwb_data,
    input  stall, ex_valid, ex_ctrl, ex_rs, ex_rt, ex_rd, ex_imm, ex_opA, ex_opB,
           ex_store_data, bubble_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_rd, id_uses_rt, id_ctrl, id_imm, id_regA, id_regB,
           flush, exmem_regwrite, exmem_rd, exmem_data, memwb_regwrite, memwb_rd, memwb_data,
    output stall, ex_valid, ex_ctrl, ex_rs, ex_rt, ex_rd, ex_imm, ex_opA, ex_opB,
           ex_store_data, bubble_cnt
  );
endinterface

// File: rtl/fwd_mux.sv
// One EX operand: picks the youngest in-flight producer of srcIdx, else the
// value latched from the register file. $0 is never forwarded.
module fwd_mux import mips_pkg::*; #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic [RW-1:0] srcIdx,
  input  logic [DW-1:0] regVal,
  input  logic          exmemRegWrite,
  input  logic [RW-1:0] exmemRd,
  input  logic [DW-1:0] exmemData,
  input  logic          memwbRegWrite,
  input  logic [RW-1:0] memwbRd,
  input  logic [DW-1:0] memwbData,
  output logic [DW-1:0] operand
);

  // EX/MEM is younger than MEM/WB, so it is checked first.
  always_comb begin
    operand = regVal;
    if (exmemRegWrite && (exmemRd != RW'(REG_ZERO)) && (exmemRd == srcIdx)) begin
      operand = exmemData;
    end else if (memwbRegWrite && (memwbRd != RW'(REG_ZERO)) && (memwbRd == srcIdx)) begin
      operand = memwbData;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion
// and EX-stage operand forwarding.
module id_ex_stage import mips_pkg::*; #(
  parameter int DW     = 32,
  parameter int RW     = 5,
  parameter int CTRL_W = mips_pkg::CTRL_W,
  parameter int CNT_W  = 16
) (
  input logic         clk,
  input logic         rst_n,
  id_ex_stage_if.slave bus
);

  logic              exValidQ;
  logic [CTRL_W-1:0] exCtrlQ;
  logic [RW-1:0]     exRsQ;
  logic [RW-1:0]     exRtQ;
  logic [RW-1:0]     exRdQ;
  logic [DW-1:0]     exImmQ;
  logic [DW-1:0]     exRegAQ;
  logic [DW-1:0]     exRegBQ;
  logic [CNT_W-1:0]  bubbleCntQ;
  logic              hazard;
  logic              bubble;

  // Load in EX whose destination is a source of the ID instruction.
  always_comb begin
    hazard = 1'b0;
    if (exValidQ && exCtrlQ[CTRL_MEMREAD] && (exRtQ != RW'(REG_ZERO)) && bus.id_valid) begin
      hazard = (exRtQ == bus.id_rs) || (bus.id_uses_rt && (exRtQ == bus.id_rt));
    end
  end

  // A flushed instruction is dead, so it never needs to be held.
  assign bubble    = bus.flush | hazard;
  assign bus.stall = hazard & ~bus.flush;

  // Pipeline register: bubble on flush/hazard, otherwise capture ID.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exValidQ   <= 1'b0;
      exCtrlQ    <= '0;
      exRsQ      <= '0;
      exRtQ      <= '0;
      exRdQ      <= '0;
      exImmQ     <= '0;
      exRegAQ    <= '0;
      exRegBQ    <= '0;
      bubbleCntQ <= '0;
    end else if (bubble) begin
      exValidQ <= 1'b0;
      exCtrlQ  <= '0;
      if (bubbleCntQ != {CNT_W{1'b1}}) begin
        bubbleCntQ <= bubbleCntQ + CNT_W'(1);
      end
    end else begin
      exValidQ <= bus.id_valid;
      exCtrlQ  <= bus.id_valid ? bus.id_ctrl : '0;
      exRsQ    <= bus.id_rs;
      exRtQ    <= bus.id_rt;
      exRdQ    <= bus.id_rd;
      exImmQ   <= bus.id_imm;
      exRegAQ  <= bus.id_regA;
      exRegBQ  <= bus.id_regB;
    end
  end

  fwd_mux #(.DW(DW), .RW(RW)) u_fwd_a (
    .srcIdx        (exRsQ),
    .regVal        (exRegAQ),
    .exmemRegWrite (bus.exmem_regwrite),
    .exmemRd       (bus.exmem_rd),
    .exmemData     (bus.exmem_data),
    .memwbRegWrite (bus.memwb_regwrite),
    .memwbRd       (bus.memwb_rd),
    .memwbData     (bus.memwb_data),
    .operand       (bus.ex_opA)
  );

  fwd_mux #(.DW(DW), .RW(RW)) u_fwd_b (
    .srcIdx        (exRtQ),
    .regVal        (exRegBQ),
    .exmemRegWrite (bus.exmem_regwrite),
    .exmemRd       (bus.exmem_rd),
    .exmemData     (bus.exmem_data),
    .memwbRegWrite (bus.memwb_regwrite),
    .memwbRd       (bus.memwb_rd),
    .memwbData     (bus.memwb_data),
    .operand       (bus.ex_opB)
  );

  // Store data is the forwarded rt value, taken before the ALUSrc mux.
  assign bus.ex_store_data = bus.ex_opB;
  assign bus.ex_valid      = exValidQ;
  assign bus.ex_ctrl       = exCtrlQ;
  assign bus.ex_rs         = exRsQ;
  assign bus.ex_rt         = exRtQ;
  assign bus.ex_rd         = exRdQ;
  assign bus.ex_imm        = exImmQ;
  assign bus.bubble_cnt    = bubbleCntQ;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: expected EX register contents are queued
// when each ID instruction is driven and compared after the capturing edge.
module tb_id_ex_stage;
  import mips_pkg::*;

  localparam int DW    = 32;
  localparam int RW    = 5;
  localparam int CW    = mips_pkg::CTRL_W;
  localparam int CNT_W = 8;
  localparam int EW    = 1 + CW + 3 * RW + DW + CNT_W;

  // {RegWrite,MemRead,MemWrite,MemToReg,ALUSrc,Branch,ALUOp}
  localparam logic [CW-1:0] LW_CTRL = 9'b1_1_0_1_1_0_000;
  localparam logic [CW-1:0] R_CTRL  = 9'b1_0_0_0_0_0_010;
  localparam logic [CW-1:0] SW_CTRL = 9'b0_0_1_0_1_0_000;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  id_ex_stage_if #(.DW(DW), .RW(RW), .CTRL_W(CW), .CNT_W(CNT_W)) bus ();

  id_ex_stage #(.DW(DW), .RW(RW), .CTRL_W(CW), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  // scoreboard
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] msk_q[$];

  // reference model of the EX register
  logic              m_valid;
  logic [CW-1:0]     m_ctrl;
  logic [RW-1:0]     m_rs, m_rt, m_rd;
  logic [DW-1:0]     m_imm;
  logic [CNT_W-1:0]  m_cnt;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_ctrl = '0; m_rs = '0; m_rt = '0; m_rd = '0; m_imm = '0; m_cnt = '0;
  endtask

  function automatic logic [EW-1:0] pack_obs();
    return {bus.ex_valid, bus.ex_ctrl, bus.ex_rs, bus.ex_rt, bus.ex_rd, bus.ex_imm, bus.bubble_cnt};
  endfunction

  // driver tasks
  task automatic drive_id(input logic v, input logic [RW-1:0] rs, input logic [RW-1:0] rt,
                          input logic [RW-1:0] rd, input logic ur, input logic [CW-1:0] c,
                          input logic [DW-1:0] imm, input logic [DW-1:0] a, input logic [DW-1:0] b);
    bus.id_valid = v; bus.id_rs = rs; bus.id_rt = rt; bus.id_rd = rd; bus.id_uses_rt = ur;
    bus.id_ctrl = c; bus.id_imm = imm; bus.id_regA = a; bus.id_regB = b;
  endtask

  task automatic set_fwd(input logic ew, input logic [RW-1:0] erd, input logic [DW-1:0] ed,
                         input logic mw, input logic [RW-1:0] mrd, input logic [DW-1:0] md);
    bus.exmem_regwrite = ew; bus.exmem_rd = erd; bus.exmem_data = ed;
    bus.memwb_regwrite = mw; bus.memwb_rd = mrd; bus.memwb_data = md;
  endtask

  // One clock: check stall, queue the expected capture, clock, compare.
  task automatic step(input string tag);
    logic          hz;
    logic [EW-1:0] e, mk, o;
    hz = m_valid && m_ctrl[CTRL_MEMREAD] && (m_rt != 0) && bus.id_valid &&
         ((m_rt == bus.id_rs) || (bus.id_uses_rt && (m_rt == bus.id_rt)));
    #1;
    chk({tag, "/stall"}, 80'(bus.stall), 80'(hz && !bus.flush));
    if (bus.flush || hz) begin
      m_valid = 1'b0; m_ctrl = '0;
      if (m_cnt != '1) m_cnt = m_cnt + 1'b1;
      mk = {1'b1, {CW{1'b1}}, {(3 * RW + DW){1'b0}}, {CNT_W{1'b1}}};
    end else begin
      m_valid = bus.id_valid; m_ctrl = bus.id_valid ? bus.id_ctrl : '0;
      m_rs = bus.id_rs; m_rt = bus.id_rt; m_rd = bus.id_rd; m_imm = bus.id_imm;
      mk = '1;
    end
    exp_q.push_back({m_valid, m_ctrl, m_rs, m_rt, m_rd, m_imm, m_cnt});
    msk_q.push_back(mk);
    @(posedge clk); #1;
    o  = pack_obs();
    e  = exp_q.pop_front();
    mk = msk_q.pop_front();
    chk({tag, "/ex"}, 80'(o & mk), 80'(e & mk));
  endtask

  initial begin
    model_reset();
    bus.flush = 1'b0;
    drive_id(1'b0, 0, 0, 0, 1'b0, '0, '0, '0, '0);
    set_fwd(1'b0, 0, '0, 1'b0, 0, '0);

    // reset state
    #22;
    chk("rst_ex", 80'(pack_obs()), 80'(0));
    chk("rst_opA", 80'(bus.ex_opA), 80'(0));
    chk("rst_stall", 80'(bus.stall), 80'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // load-use: lw $8 then add $9,$8,$4
    drive_id(1'b1, 29, 8, 8, 1'b0, LW_CTRL, 32'h4, 32'h1000, 32'h77);
    step("lw8");
    drive_id(1'b1, 8, 4, 9, 1'b1, R_CTRL, 32'h0, 32'hDEAD, 32'h44);
    #1 chk("t2_stall", 80'(bus.stall), 80'(1));
    step("add_hold");
    chk("t2_bubble_valid", 80'(bus.ex_valid), 80'(0));
    chk("t2_cnt", 80'(bus.bubble_cnt), 80'(1));
    step("add_go");
    set_fwd(1'b0, 0, '0, 1'b1, 8, 32'h113D4);
    #1;
    chk("t2_opA", 80'(bus.ex_opA), 80'(32'h113D4));
    chk("t2_opB", 80'(bus.ex_opB), 80'(32'h44));
    set_fwd(1'b0, 0, '0, 1'b0, 0, '0);

    // ALU-to-ALU: add $2 then sub $3,$2,$2; EX/MEM beats MEM/WB
    drive_id(1'b1, 5, 6, 2, 1'b1, R_CTRL, 32'h0, 32'h5, 32'h6);
    step("add2");
    drive_id(1'b1, 2, 2, 3, 1'b1, R_CTRL, 32'h0, 32'h111, 32'h222);
    step("sub3");
    set_fwd(1'b1, 2, 32'hAAAA5555, 1'b1, 2, 32'h12345678);
    #1;
    chk("t3_opA", 80'(bus.ex_opA), 80'(32'hAAAA5555));
    chk("t3_opB", 80'(bus.ex_opB), 80'(32'hAAAA5555));
    chk("t3_store", 80'(bus.ex_store_data), 80'(32'hAAAA5555));
    set_fwd(1'b0, 2, 32'hAAAA5555, 1'b1, 2, 32'h12345678);
    #1 chk("t3_memwb_opA", 80'(bus.ex_opA), 80'(32'h12345678));
    set_fwd(1'b0, 0, '0, 1'b0, 0, '0);
    #1 chk("t3_reg_opB", 80'(bus.ex_opB), 80'(32'h222));

    // $0 is never forwarded and never causes a load-use stall
    drive_id(1'b1, 0, 0, 7, 1'b1, R_CTRL, 32'h0, 32'h0, 32'h0);
    step("use_r0");
    set_fwd(1'b1, 0, 32'hBAD1, 1'b1, 0, 32'hBAD2);
    #1;
    chk("t4_opA", 80'(bus.ex_opA), 80'(0));
    chk("t4_opB", 80'(bus.ex_opB), 80'(0));
    set_fwd(1'b0, 0, '0, 1'b0, 0, '0);
    drive_id(1'b1, 29, 0, 0, 1'b0, LW_CTRL, 32'h8, 32'h1000, 32'h0);
    step("lw0");
    drive_id(1'b1, 0, 0, 9, 1'b1, R_CTRL, 32'h0, 32'h0, 32'h0);
    #1 chk("t4_stall", 80'(bus.stall), 80'(0));
    step("use0_after_lw0");
    chk("t4_cnt", 80'(bus.bubble_cnt), 80'(1));

    // asynchronous reset mid-stream
    drive_id(1'b1, 3, 4, 5, 1'b1, R_CTRL, 32'hABC, 32'h1, 32'h2);
    step("pre_rst");
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_ex", 80'(pack_obs()), 80'(0));
    chk("mid_rst_opA", 80'(bus.ex_opA), 80'(0));
    model_reset();
    #1 rst_n = 1'b1;
    drive_id(1'b1, 6, 7, 8, 1'b1, R_CTRL, 32'h123, 32'h66, 32'h77);
    step("post_rst");

    // flush during a load-use hazard: one bubble, no stall
    drive_id(1'b1, 29, 10, 10, 1'b0, LW_CTRL, 32'h0, 32'h2000, 32'h0);
    step("lw10");
    drive_id(1'b1, 10, 3, 4, 1'b1, R_CTRL, 32'h0, 32'h0, 32'h0);
    bus.flush = 1'b1;
    #1 chk("t5_stall", 80'(bus.stall), 80'(0));
    step("flush_hz");
    chk("t5_cnt", 80'(bus.bubble_cnt), 80'(1));
    chk("t5_ctrl", 80'(bus.ex_ctrl), 80'(0));
    bus.flush = 1'b0;
    drive_id(1'b1, 1, 2, 3, 1'b1, R_CTRL, 32'h0, 32'h0, 32'h0);
    step("after_flush");

    // id_valid=0: control zeroed, not counted as a bubble
    drive_id(1'b0, 1, 2, 3, 1'b1, R_CTRL, 32'h55, 32'h0, 32'h0);
    step("idle");
    chk("idle_ctrl", 80'(bus.ex_ctrl), 80'(0));
    chk("idle_cnt", 80'(bus.bubble_cnt), 80'(1));

    // store after an unrelated load
    drive_id(1'b1, 29, 11, 11, 1'b0, LW_CTRL, 32'h0, 32'h0, 32'h0);
    step("lw11");
    drive_id(1'b1, 12, 13, 0, 1'b1, SW_CTRL, 32'h10, 32'h300, 32'h400);
    #1 chk("t6_stall", 80'(bus.stall), 80'(0));
    step("sw");
    chk("t6_ctrl", 80'(bus.ex_ctrl), 80'(SW_CTRL));

    // bubble counter saturation
    bus.flush = 1'b1;
    for (int i = 0; i < (1 << CNT_W) + 4; i++) step("sat");
    chk("sat_cnt", 80'(bus.bubble_cnt), 80'({CNT_W{1'b1}}));
    bus.flush = 1'b0;

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
